wb_fir_bridge: RTL and testbench

// - Wishbone-slave to AXI bridge; sits directly upstream of the FIR wrapper in the Caravel user area.
// - Converts management-SoC Wishbone cycles into three kinds of FIR transaction:
//   - AXI-Lite config writes and reads (taps, length, ap_ctrl);
//   - AXI-Stream X pushes into ss_*;
//   - AXI-Stream Y pops from sm_*.
// - Generates ss_tlast from a shadow copy of the data-length register.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/wb_fir_tlast_gen.sv | 52 +++++
 rtl/wb_fir_bridge.sv | 248 ++++++++++++++++++++++++
 tb/tb_wb_fir_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the Wishbone-to-FIR bridge:
//   - fir_state_e  : bridge transaction FSM states
//   - FIR_OFF_*    : FIR register / stream window offsets (12-bit)
//   - TIMEOUT_DATA : word returned on a Y read that timed out
// -----------------------------------------------------------------------------
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LW    = 3'd1,
    ST_LR_A  = 3'd2,
    ST_LR_D  = 3'd3,
    ST_SS_WR = 3'd4,
    ST_SM_RD = 3'd5,
    ST_ACK   = 3'd6
  } fir_state_e;

  localparam logic [11:0] FIR_OFF_AP_CTRL = 12'h000;
  localparam logic [11:0] FIR_OFF_LEN     = 12'h010;
  localparam logic [11:0] FIR_OFF_X       = 12'h080;
  localparam logic [11:0] FIR_OFF_Y       = 12'h084;

  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_fir_tlast_gen.sv
// -----------------------------------------------------------------------------
// wb_fir_tlast_gen
// Keeps a shadow of the FIR data-length register and counts X beats so the
// bridge can flag the last sample of a frame on ss_tlast.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_len_load     load r_len_q from i_len_data (AXI-Lite write to LEN)
//   i_len_data     data-length value being written to the FIR
//   i_cnt_clr      clear the beat counter (ap_start written)
//   i_beat         one X beat accepted by the FIR this cycle
//   o_tlast        current beat is the last of the frame
// -----------------------------------------------------------------------------
module wb_fir_tlast_gen
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_len_load,
  input  logic [pDATA_WIDTH-1:0] i_len_data,
  input  logic                   i_cnt_clr,
  input  logic                   i_beat,
  output logic                   o_tlast
);

  localparam logic [pDATA_WIDTH-1:0] ZERO = {pDATA_WIDTH{1'b0}};

  logic [pDATA_WIDTH-1:0] r_len_q;
  logic [pDATA_WIDTH-1:0] r_x_cnt;

  // A zero length means "no framing": tlast is never raised and the counter free-runs.
  assign o_tlast = (r_len_q != ZERO) && (r_x_cnt == (r_len_q - 1'b1));

  // Length shadow and beat counter; the counter wraps right after the tlast beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_q <= ZERO;
      r_x_cnt <= ZERO;
    end else begin
      if (i_len_load) begin
        r_len_q <= i_len_data;
      end
      if (i_cnt_clr) begin
        r_x_cnt <= ZERO;
      end else if (i_beat) begin
        r_x_cnt <= o_tlast ? ZERO : (r_x_cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/wb_fir_bridge.sv
// -----------------------------------------------------------------------------
// wb_fir_bridge
// Wishbone classic slave that turns management-SoC accesses into FIR traffic:
//   - any offset except X/Y  : AXI-Lite write (LW) or read (LR_A/LR_D)
//   - X_OFFSET write         : one AXI-Stream beat on ss_*
//   - Y_OFFSET read          : one AXI-Stream beat popped from sm_*
//   - X_OFFSET read / Y_OFFSET write : acknowledged with 0, no FIR traffic
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_*                       Wishbone slave (sel ignored, full words only)
//   aw*/w*/ar*/r*               AXI-Lite master towards the FIR config space
//   ss_*                        AXI-Stream master (X samples), tlast generated
//   sm_*                        AXI-Stream slave (Y samples)
// All outputs except sm_tready are registered; sm_tready is combinational so
// that it is high only in the very cycle a Y sample is taken.
// -----------------------------------------------------------------------------
module wb_fir_bridge
  import fir_pkg::*;
#(
  parameter logic [31:0]            BASE_ADDR   = 32'h3000_0000,
  parameter int                     pADDR_WIDTH = 12,
  parameter int                     pDATA_WIDTH = 32,
  parameter logic [pADDR_WIDTH-1:0] X_OFFSET    = FIR_OFF_X,
  parameter logic [pADDR_WIDTH-1:0] Y_OFFSET    = FIR_OFF_Y,
  parameter logic [pADDR_WIDTH-1:0] LEN_OFFSET  = FIR_OFF_LEN,
  parameter int                     Y_TIMEOUT   = 1024
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [pDATA_WIDTH-1:0] wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [pDATA_WIDTH-1:0] wbs_dat_o,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready
);

  localparam int                     TO_W      = $clog2(Y_TIMEOUT + 1);
  localparam logic [TO_W-1:0]        TO_LAST   = TO_W'(Y_TIMEOUT - 1);
  localparam logic [pADDR_WIDTH-1:0] AP_OFFSET = pADDR_WIDTH'(FIR_OFF_AP_CTRL);
  localparam logic [pDATA_WIDTH-1:0] D_ZERO    = {pDATA_WIDTH{1'b0}};
  localparam logic [pADDR_WIDTH-1:0] A_ZERO    = {pADDR_WIDTH{1'b0}};

  fir_state_e             r_state;
  logic [pADDR_WIDTH-1:0] r_adr;
  logic                   r_aw_done;
  logic                   r_w_done;
  logic [TO_W-1:0]        r_to_cnt;

  logic                   w_hit;
  logic [pADDR_WIDTH-1:0] w_off;
  logic                   w_req;
  logic                   w_aw_done;
  logic                   w_w_done;
  logic                   w_lw_fin;
  logic                   w_len_load;
  logic                   w_cnt_clr;
  logic                   w_beat;
  logic                   w_tlast;
  logic                   w_unused;

  // Byte selects and the Y-side tlast carry no information for this bridge.
  assign w_unused = &{1'b0, wbs_sel_i, sm_tlast};

  assign w_off = wbs_adr_i[pADDR_WIDTH-1:0];
  assign w_hit = (wbs_adr_i[31:pADDR_WIDTH] == BASE_ADDR[31:pADDR_WIDTH]);
  assign w_req = wbs_cyc_i && wbs_stb_i && w_hit;

  // A handshake counts as done if it completed earlier or completes this cycle.
  assign w_aw_done = r_aw_done || (awvalid && awready);
  assign w_w_done  = r_w_done  || (wvalid && wready);
  assign w_lw_fin  = (r_state == ST_LW) && w_aw_done && w_w_done;

  // Shadow updates happen on the edge the AXI-Lite write completes.
  assign w_len_load = w_lw_fin && (r_adr == LEN_OFFSET);
  assign w_cnt_clr  = w_lw_fin && (r_adr == AP_OFFSET) && wdata[0];
  assign w_beat     = (r_state == ST_SS_WR) && ss_tvalid && ss_tready;

  // Y pop: accept exactly in the cycle the FIR presents a sample.
  assign sm_tready = (r_state == ST_SM_RD) && sm_tvalid;

  wb_fir_tlast_gen #(
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_tlast (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_len_load (w_len_load),
    .i_len_data (wdata),
    .i_cnt_clr  (w_cnt_clr),
    .i_beat     (w_beat),
    .o_tlast    (w_tlast)
  );

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_adr     <= A_ZERO;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_to_cnt  <= {TO_W{1'b0}};
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= D_ZERO;
      awvalid   <= 1'b0;
      awaddr    <= A_ZERO;
      wvalid    <= 1'b0;
      wdata     <= D_ZERO;
      arvalid   <= 1'b0;
      araddr    <= A_ZERO;
      rready    <= 1'b0;
      ss_tvalid <= 1'b0;
      ss_tdata  <= D_ZERO;
      ss_tlast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_adr <= w_off;
            if ((w_off == X_OFFSET) && wbs_we_i) begin
              ss_tvalid <= 1'b1;
              ss_tdata  <= wbs_dat_i;
              ss_tlast  <= w_tlast;
              r_state   <= ST_SS_WR;
            end else if ((w_off == Y_OFFSET) && !wbs_we_i) begin
              r_to_cnt <= {TO_W{1'b0}};
              r_state  <= ST_SM_RD;
            end else if ((w_off == X_OFFSET) || (w_off == Y_OFFSET)) begin
              // Wrong-direction stream access: complete it without touching the FIR.
              wbs_dat_o <= D_ZERO;
              wbs_ack_o <= 1'b1;
              r_state   <= ST_ACK;
            end else if (wbs_we_i) begin
              awvalid   <= 1'b1;
              awaddr    <= w_off;
              wvalid    <= 1'b1;
              wdata     <= wbs_dat_i;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_LW;
            end else begin
              arvalid <= 1'b1;
              araddr  <= w_off;
              r_state <= ST_LR_A;
            end
          end
        end

        ST_LW: begin
          if (awvalid && awready) begin
            awvalid   <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid   <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_done && w_w_done) begin
            wbs_dat_o <= D_ZERO;
            wbs_ack_o <= 1'b1;
            r_state   <= ST_ACK;
          end
        end

        ST_LR_A: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= ST_LR_D;
          end
        end

        ST_LR_D: begin
          if (rvalid) begin
            rready    <= 1'b0;
            wbs_dat_o <= rdata;
            wbs_ack_o <= 1'b1;
            r_state   <= ST_ACK;
          end
        end

        ST_SS_WR: begin
          if (ss_tready) begin
            ss_tvalid <= 1'b0;
            ss_tlast  <= 1'b0;
            wbs_dat_o <= D_ZERO;
            wbs_ack_o <= 1'b1;
            r_state   <= ST_ACK;
          end
        end

        ST_SM_RD: begin
          // A sample arriving on the last wait cycle still wins over the timeout.
          if (sm_tvalid) begin
            wbs_dat_o <= sm_tdata;
            wbs_ack_o <= 1'b1;
            r_state   <= ST_ACK;
          end else if (r_to_cnt == TO_LAST) begin
            wbs_dat_o <= pDATA_WIDTH'(TIMEOUT_DATA);
            wbs_ack_o <= 1'b1;
            r_state   <= ST_ACK;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= D_ZERO;
          r_state   <= ST_IDLE;
        end

        default: begin
          wbs_ack_o <= 1'b0;
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          arvalid   <= 1'b0;
          rready    <= 1'b0;
          ss_tvalid <= 1'b0;
          ss_tlast  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fir_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_fir_bridge
// Directed bench for wb_fir_bridge. The bench plays the Wishbone master and
// the FIR (AXI-Lite slave, X sink, Y source) cycle by cycle. Inputs change
// and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_fir_bridge;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        sm_tvalid, sm_tlast, sm_tready;
  logic [31:0] sm_tdata;

  int tests = 0;
  int fails = 0;

  wb_fir_bridge dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .awvalid   (awvalid),
    .awaddr    (awaddr),
    .awready   (awready),
    .wvalid    (wvalid),
    .wdata     (wdata),
    .wready    (wready),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .arready   (arready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rready    (rready),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready),
    .sm_tvalid (sm_tvalid),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast),
    .sm_tready (sm_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {ack, dat_o, awvalid, wvalid, arvalid, rready, awaddr, araddr, wdata,
                ss_tvalid, ss_tlast, ss_tdata, sm_tready}, 128'd0);
  endtask

  // Present a Wishbone request and let the bridge sample it.
  task automatic wb_req(input logic [31:0] a, input logic [31:0] d, input logic w);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    tick();
  endtask

  task automatic wb_end();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  // AXI-Lite write; mode 0: awready first, 1: wready first, 2: both together.
  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d, input int mode);
    wb_req(a, d, 1'b1);
    check("lw_valids", {awvalid, wvalid, ack}, 3'b110);
    check("lw_awaddr", awaddr, a[11:0]);
    check("lw_wdata", wdata, d);
    if (mode == 0) begin
      awready = 1'b1; tick(); awready = 1'b0;
      check("lw_aw_first", {awvalid, wvalid, ack}, 3'b010);
      wready = 1'b1; tick(); wready = 1'b0;
    end else if (mode == 1) begin
      wready = 1'b1; tick(); wready = 1'b0;
      check("lw_w_first", {awvalid, wvalid, ack}, 3'b100);
      awready = 1'b1; tick(); awready = 1'b0;
    end else begin
      awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0;
    end
    check("lw_ack", {awvalid, wvalid, ack}, 3'b001);
    wb_end();
    check("lw_ack_drop", ack, 1'b0);
  endtask

  // X push with the sink ready one cycle after the request.
  task automatic x_push(input logic [31:0] d, input logic exp_last);
    wb_req(32'h3000_0080, d, 1'b1);
    check("x_tvalid", {ss_tvalid, ss_tlast, ack}, {1'b1, exp_last, 1'b0});
    check("x_tdata", ss_tdata, d);
    ss_tready = 1'b1; tick(); ss_tready = 1'b0;
    check("x_ack", {ss_tvalid, ack}, 2'b01);
    wb_end();
  endtask

  initial begin
    int n;
    logic seen_tready;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = 32'd0; dat_i = 32'd0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = 32'd0; sm_tlast = 1'b0;

    // Reset state
    tick(); tick();
    check_all_zero("reset_outs");
    rst = 1'b0;
    tick();

    // Config writes to 0x040 = 5, each ready ordering
    cfg_write(32'h3000_0040, 32'd5, 0);
    cfg_write(32'h3000_0040, 32'd5, 1);
    cfg_write(32'h3000_0040, 32'd5, 2);

    // Config read of 0x040, rvalid three cycles after entering the data phase
    wb_req(32'h3000_0040, 32'd0, 1'b0);
    check("lr_ar", {arvalid, rready, ack}, 3'b100);
    check("lr_araddr", araddr, 12'h040);
    arready = 1'b1; tick(); arready = 1'b0;
    check("lr_ar_done", {arvalid, rready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lr_wait", {rready, ack}, 2'b10);
    end
    rvalid = 1'b1; rdata = 32'd5; tick(); rvalid = 1'b0; rdata = 32'd0;
    check("lr_ack", {rready, ack}, 2'b01);
    check("lr_data", dat_o, 32'd5);
    wb_end();
    check("lr_rready_idle", rready, 1'b0);

    // Stream of 4 with length 4: tlast only on beat 4, twice to show the wrap
    cfg_write(32'h3000_0010, 32'd4, 2);
    x_push(32'hA0, 1'b0);
    x_push(32'hA1, 1'b0);
    x_push(32'hA2, 1'b0);
    x_push(32'hA3, 1'b1);
    check("x_cnt_wrap", dut.u_tlast.r_x_cnt, 32'd0);
    x_push(32'hB0, 1'b0);
    x_push(32'hB1, 1'b0);
    x_push(32'hB2, 1'b0);
    x_push(32'hB3, 1'b1);

    // Backpressure: ss_tready low for 10 cycles
    wb_req(32'h3000_0080, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {ss_tvalid, ack, ss_tdata}, {2'b10, 32'hDEAD_BEEF});
      tick();
    end
    ss_tready = 1'b1; tick(); ss_tready = 1'b0;
    check("bp_ack", {ss_tvalid, ack}, 2'b01);
    wb_end();
    check("bp_cnt", dut.u_tlast.r_x_cnt, 32'd1);

    // ap_start write clears the beat counter
    cfg_write(32'h3000_0000, 32'd1, 2);
    check("ap_start_clr", dut.u_tlast.r_x_cnt, 32'd0);

    // Y read with a sample after two idle cycles
    wb_req(32'h3000_0084, 32'd0, 1'b0);
    check("y_idle0", {sm_tready, ack}, 2'b00);
    tick();
    check("y_idle1", {sm_tready, ack}, 2'b00);
    tick();
    sm_tvalid = 1'b1; sm_tdata = 32'h0000_1234;
    #1;
    check("y_tready", sm_tready, 1'b1);
    tick();
    check("y_tready_once", {sm_tready, ack}, 2'b01);
    check("y_data", dat_o, 32'h0000_1234);
    sm_tvalid = 1'b0; sm_tdata = 32'd0;
    wb_end();

    // Y read timeout: ack after exactly 1024 cycles with all-ones
    wb_req(32'h3000_0084, 32'd0, 1'b0);
    n = 0;
    seen_tready = 1'b0;
    while (!ack && n < 2000) begin
      tick();
      n++;
      if (sm_tready) seen_tready = 1'b1;
    end
    check("y_to_cycles", n, 32'd1024);
    check("y_to_data", dat_o, 32'hFFFF_FFFF);
    check("y_to_no_tready", seen_tready, 1'b0);
    wb_end();

    // Wrong-direction stream accesses ack immediately with 0
    wb_req(32'h3000_0080, 32'h55, 1'b0);
    check("x_read_ack", {ack, ss_tvalid, dat_o}, {2'b10, 32'd0});
    wb_end();
    wb_req(32'h3000_0084, 32'h66, 1'b1);
    check("y_write_ack", {ack, awvalid, dat_o}, {2'b10, 32'd0});
    wb_end();

    // Reset in the middle of an X push
    wb_req(32'h3000_0080, 32'h77, 1'b1);
    check("rst_pre", ss_tvalid, 1'b1);
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid_ss");
    check("rst_len", dut.u_tlast.r_len_q, 32'd0);
    rst = 1'b0;
    wb_end();

    // Non-hit address never acks or starts traffic
    wb_req(32'h3100_0000, 32'h9, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("nonhit", {ack, awvalid, wvalid, arvalid, ss_tvalid}, 5'b00000);
      tick();
    end
    wb_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
